// File: rtl/fp_pkg.sv
// Shared types and constants for the FP add/sub back end.
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized mantissa; renormalizes when rounding carries out.
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [MAN_W+1:0] mant_i,
  input  logic             g_i,
  input  logic             r_i,
  input  logic             s_i,
  output logic [MAN_W:0]   mant_o,
  output logic             carry_o,
  output logic             inexact_o
);

  logic             round_up_s;
  logic [MAN_W+1:0] sum_s;

  // Ties go to the even neighbour via mant_i[0]; a carry means the sum hit 2.0.
  always_comb begin
    round_up_s = g_i & (r_i | s_i | mant_i[0]);
    sum_s      = mant_i + {{(MAN_W+1){1'b0}}, round_up_s};
    carry_o    = sum_s[MAN_W+1];
    mant_o     = carry_o ? sum_s[MAN_W+1:1] : sum_s[MAN_W:0];
    inexact_o  = g_i | r_i | s_i;
  end

endmodule

// File: rtl/fp_normalize_pack.sv
// Iterative normalizer, RNE rounder and IEEE-754 single packer with valid/ready on both sides.
module fp_normalize_pack
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [EXP_W-1:0] exponent,
  input  logic [MAN_W+1:0] mantissa,
  input  logic [2:0]       grs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic             overflow,
  output logic             underflow,
  output logic             inexact
);

  localparam int XW = EXP_W + 2;
  localparam logic [XW-1:0] EXP_MAX_X = XW'(EXP_MAX);
  localparam logic [4:0]    MAX_LSH   = 5'd23;

  state_e           state_q, state_d;
  logic [MAN_W+1:0] mant_q, mant_d;
  logic             g_q, g_d, r_q, r_d, s_q, s_d;
  logic [XW-1:0]    exp_q, exp_d;
  logic             sign_q, sign_d, inf_q, inf_d;
  logic [4:0]       shcnt_q, shcnt_d;
  logic [31:0]      result_q, result_d;
  logic             ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d, out_valid_q, out_valid_d;

  logic [MAN_W:0]   rnd_mant_s;
  logic             rnd_carry_s, rnd_inexact_s;
  logic [XW-1:0]    exp_rnd_s;
  fp32_t            packed_s;

  fp_round_rne u_round (
    .mant_i    (mant_q),
    .g_i       (g_q),
    .r_i       (r_q),
    .s_i       (s_q),
    .mant_o    (rnd_mant_s),
    .carry_o   (rnd_carry_s),
    .inexact_o (rnd_inexact_s)
  );

  assign exp_rnd_s = exp_q + {{(XW-1){1'b0}}, rnd_carry_s};

  // Next-state and datapath for the IDLE -> NORM -> ROUND -> DONE sequence.
  always_comb begin
    state_d     = state_q;
    mant_d      = mant_q;
    g_d         = g_q;
    r_d         = r_q;
    s_d         = s_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    inf_d       = inf_q;
    shcnt_d     = shcnt_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inx_d       = inx_q;
    out_valid_d = out_valid_q;
    packed_s    = '{sign: sign_q, exp: exp_rnd_s[EXP_W-1:0], frac: rnd_mant_s[MAN_W-1:0]};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d   = mantissa;
          g_d      = grs[2];
          r_d      = grs[1];
          s_d      = grs[0];
          exp_d    = {2'b00, exponent};
          sign_d   = sign;
          inf_d    = (exponent == EXP_MAX_X[EXP_W-1:0]);
          shcnt_d  = 5'd0;
          result_d = 32'h0000_0000;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          state_d  = NORM;
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if ((mant_q == '0) && !(g_q | r_q | s_q)) begin
          result_d    = 32'h0000_0000;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (inf_q) begin
          result_d    = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (mant_q[MAN_W+1]) begin
          // Carry: the old guard slides into round, round folds into sticky.
          mant_d  = {1'b0, mant_q[MAN_W+1:1]};
          g_d     = mant_q[0];
          r_d     = g_q;
          s_d     = r_q | s_q;
          exp_d   = exp_q + {{(XW-1){1'b0}}, 1'b1};
          state_d = ROUND;
        end else if (mant_q[MAN_W]) begin
          state_d = ROUND;
        end else if ((exp_q <= {{(XW-1){1'b0}}, 1'b1}) || (shcnt_q == MAX_LSH)) begin
          result_d    = {sign_q, 31'h0000_0000};
          unf_d       = 1'b1;
          inx_d       = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          mant_d  = {mant_q[MAN_W:0], g_q};
          g_d     = r_q;
          r_d     = 1'b0;
          exp_d   = exp_q - {{(XW-1){1'b0}}, 1'b1};
          shcnt_d = shcnt_q + 5'd1;
          state_d = NORM;
        end
      end
      ROUND: begin
        mant_d = {1'b0, rnd_mant_s};
        exp_d  = exp_rnd_s;
        inx_d  = rnd_inexact_s;
        if (exp_rnd_s >= EXP_MAX_X) begin
          result_d = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          ovf_d    = 1'b1;
        end else begin
          result_d = packed_s;
        end
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, working registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mant_q      <= '0;
      g_q         <= 1'b0;
      r_q         <= 1'b0;
      s_q         <= 1'b0;
      exp_q       <= '0;
      sign_q      <= 1'b0;
      inf_q       <= 1'b0;
      shcnt_q     <= 5'd0;
      result_q    <= 32'h0000_0000;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inx_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mant_q      <= mant_d;
      g_q         <= g_d;
      r_q         <= r_d;
      s_q         <= s_d;
      exp_q       <= exp_d;
      sign_q      <= sign_d;
      inf_q       <= inf_d;
      shcnt_q     <= shcnt_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inx_q       <= inx_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Self-checking bench for fp_normalize_pack: directed vectors plus random ops against an arithmetic model.
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        sign = 1'b0;
  logic [7:0]  exponent = 8'd0;
  logic [24:0] mantissa = 25'd0;
  logic [2:0]  grs = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow, underflow, inexact;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_normalize_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exponent(exponent), .mantissa(mantissa), .grs(grs),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .inexact(inexact)
  );

  // Value view: w = mant*8 + {g,r,s}; exponent tracked as a plain int.
  function automatic void model(input bit sg, input int e, input int m, input int grs_v,
                                output bit [31:0] res, output bit ov, output bit un,
                                output bit ix, output int lat);
    int w, ex, sh, mn, g, r, s, up;
    w = m * 8 + grs_v; ex = e; sh = 0;
    res = 32'h0; ov = 1'b0; un = 1'b0; ix = 1'b0;
    if (w == 0) begin lat = 1; return; end
    if (e == 255) begin res = {sg, 8'hFF, 23'h0}; ov = 1'b1; lat = 1; return; end
    if (w >= (1 << 27)) begin
      w = (w >> 1) | (w & 1);
      ex = ex + 1;
    end else begin
      while (w < (1 << 26)) begin
        if (ex <= 1 || sh == 23) begin
          res = {sg, 31'h0}; un = 1'b1; ix = 1'b1; lat = sh + 1; return;
        end
        w = ((w >> 1) << 2) | (w & 1);
        ex = ex - 1; sh = sh + 1;
      end
    end
    mn = w >> 3; g = (w >> 2) & 1; r = (w >> 1) & 1; s = w & 1;
    ix = ((w & 7) != 0);
    up = g & (r | s | (mn & 1));
    mn = mn + up;
    if (mn >= (1 << 24)) begin mn = mn >> 1; ex = ex + 1; end
    if (ex >= 255) begin res = {sg, 8'hFF, 23'h0}; ov = 1'b1; end
    else res = {sg, 8'(ex), 23'(mn & 32'h007F_FFFF)};
    lat = sh + 2;
  endfunction

  task automatic run_op(input string nm, input bit sg, input bit [7:0] e, input bit [24:0] m,
                        input bit [2:0] g3, input bit [31:0] x_res, input bit x_ov,
                        input bit x_un, input bit x_ix, input int x_lat, input int hold);
    int n;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL %s idle_ready got %b want 1", nm, in_ready); end
    in_valid = 1'b1; sign = sg; exponent = e; mantissa = m; grs = g3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL %s busy_ready got %b want 0", nm, in_ready); end
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n !== x_lat) begin failures++; $display("FAIL %s latency got %0d want %0d", nm, n, x_lat); end
    checks++;
    if (result !== x_res || {overflow, underflow, inexact} !== {x_ov, x_un, x_ix}) begin
      failures++;
      $display("FAIL %s result got %h ov/un/ix %b%b%b want %h %b%b%b", nm, result,
               overflow, underflow, inexact, x_res, x_ov, x_un, x_ix);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk); in_valid = 1'b1; sign = ~sg;
      @(posedge clk); #1;
      checks++;
      if (result !== x_res || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s hold%0d got res %h valid %b ready %b want %h 1 0", nm, i, result, out_valid, in_ready, x_res);
      end
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL %s release valid %b ready %b want 0 1", nm, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || {overflow, underflow, inexact} !== 3'b000 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset got valid %b res %h flags %b%b%b ready %b want 0 0 000 1",
               out_valid, result, overflow, underflow, inexact, in_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op("norm_1p5",  1'b0, 8'd127, 25'h0C00000, 3'b000, 32'h3FC00000, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("carry_3p0", 1'b0, 8'd127, 25'h1800000, 3'b000, 32'h40400000, 1'b0, 1'b0, 1'b0, 2, 0);
    run_op("lshift2",   1'b0, 8'd130, 25'h0200000, 3'b000, 32'h40000000, 1'b0, 1'b0, 1'b0, 4, 0);
    run_op("rne_odd",   1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 1'b0, 1'b0, 1'b1, 2, 0);
    run_op("rne_even",  1'b0, 8'd127, 25'h0800002, 3'b100, 32'h3F800002, 1'b0, 1'b0, 1'b1, 2, 0);
    run_op("overflow",  1'b0, 8'd254, 25'h1FFFFFF, 3'b111, 32'h7F800000, 1'b1, 1'b0, 1'b1, 2, 0);
    run_op("zero",      1'b1, 8'd100, 25'h0000000, 3'b000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1, 0);
    run_op("inf_in",    1'b1, 8'd255, 25'h0900000, 3'b000, 32'hFF800000, 1'b1, 1'b0, 1'b0, 1, 0);
    run_op("underflow", 1'b1, 8'd2,   25'h0100000, 3'b000, 32'h80000000, 1'b0, 1'b1, 1'b1, 2, 0);
  endtask

  task automatic test_backpressure();
    run_op("backpress", 1'b1, 8'd128, 25'h0A00000, 3'b000, 32'hC0200000, 1'b0, 1'b0, 1'b0, 2, 5);
  endtask

  task automatic test_reset_mid_norm();
    int seen;
    @(negedge clk);
    in_valid = 1'b1; sign = 1'b0; exponent = 8'd130; mantissa = 25'h0040000; grs = 3'b000;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid ready %b valid %b want 1 0", in_ready, out_valid);
    end
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL rst_mid_no_output got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_random();
    bit [31:0] x_res; bit x_ov, x_un, x_ix; int x_lat;
    bit [24:0] m; bit [7:0] e; bit [2:0] g3; bit sg; int kind;
    for (int k = 0; k < 60; k++) begin
      kind = $urandom_range(0, 4);
      sg = 1'($urandom_range(0, 1));
      e = 8'($urandom_range(2, 253));
      g3 = 3'($urandom_range(0, 7));
      m = 25'h0800000 | 25'($urandom() & 32'h007F_FFFF);
      case (kind)
        0: m = m | 25'h1000000;
        1: ;
        2: m = m >> $urandom_range(1, 22);
        3: begin e = 8'($urandom_range(0, 5)); m = m >> $urandom_range(0, 8); end
        default: begin e = 8'($urandom_range(250, 255)); if ($urandom_range(0, 1) == 1) m = m | 25'h1000000; end
      endcase
      model(sg, int'(e), int'(m), int'(g3), x_res, x_ov, x_un, x_ix, x_lat);
      run_op("random", sg, e, m, g3, x_res, x_ov, x_un, x_ix, x_lat, $urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_norm();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
Back end of the FP add/sub datapath: takes the raw, unnormalized sum or difference produced after alignment and mantissa addition, and emits a packed IEEE-754 single-precision word.
- Normalizes iteratively, one bit per cycle: right shift on carry, left shift until the hidden bit is set. This is the inverse of the alignment shifter on the input side.
- Rounds round-to-nearest-even, detects overflow and underflow, and packs {sign, exponent, fraction}.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
EXP_W, 8, exponent field width
MAN_W, 23, stored fraction width (hidden bit excluded)
EXP_MAX, 255, all-ones exponent (infinity encoding)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input operand valid
in_ready  out  1  block can accept (high only in IDLE)
sign  in  1  result sign
exponent  in  EXP_W  biased exponent before normalization
mantissa  in  MAN_W+2  bit 24 = carry, bit 23 = hidden, 22:0 = fraction
grs  in  3  guard, round, sticky bits from alignment
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  32  packed IEEE-754 word
overflow  out  1  result saturated to infinity
underflow  out  1  result flushed to zero
inexact  out  1  any nonzero g/r/s discarded

Behaviour:
Reset (async, any state):
- state=IDLE.
- out_valid=0, result=0, all flags=0, in_ready=1.

Internal state:
- Working registers: mant (25b), g, r, s.
- exp held 10b unsigned so that +1 steps cannot wrap.

IDLE:
- in_ready=1.
- On in_valid&&in_ready: capture all inputs, go NORM.

NORM, evaluated once per cycle in this priority order:
- mant==0 and grs==0: result=+0 (sign forced 0), no flags, go DONE.
- Input exponent==EXP_MAX at capture: result=signed infinity, overflow=1, go DONE.
- mant[24]=1: shift right by one (mant>>1; g=mant[0]; r=g; s=r|s), exp+1, go ROUND.
- mant[23]=1: go ROUND.
- Otherwise, exp<=1: flush to signed zero, underflow=1, inexact=1, go DONE.
- Otherwise: shift left by one (mant={mant[23:0],g}; g=r; r=0; s unchanged), exp-1, stay in NORM.
- Left shifts are bounded at 23.

ROUND:
- round_up = g & (r | s | mant[0]).
- mant += round_up.
- If mant[24] is now set: mant>>=1, exp+1.
- inexact = g|r|s.
- If exp>=EXP_MAX: result={sign,8'hFF,23'h0}, overflow=1.
- Else: result={sign,exp[7:0],mant[22:0]}.
- Go DONE.

DONE:
- out_valid=1; result and flags held stable.
- On out_ready: out_valid=0, go IDLE.
- in_ready stays 0 until IDLE, so no input is accepted in the same cycle as output.

Latency (accept edge = k):
- Already-normalized or carry input: out_valid in cycle k+3.
- Each left shift adds one cycle; worst case k+26.

Boundaries:
- out_ready held low: result held indefinitely; in_valid ignored.
- rst mid-NORM or ROUND: operation discarded, no output.
- Flags clear when a new operation is accepted.

Decomposition:
Package fp_pkg holds:
- EXP_W, MAN_W, EXP_MAX, BIAS=127.
- State enum {IDLE, NORM, ROUND, DONE}.
- Packed struct fp32_t {sign, exp, frac}.

Sub-module fp_round_rne is combinational:
- Inputs: mant, g, r, s.
- Outputs: rounded mant, carry_out, inexact.

All sequencing lives in fp_normalize_pack.

Test Plan:
1. exp=127, mant=25'h0C00000, grs=0 -> result 32'h3FC00000 (1.5), out_valid at k+3, all flags 0.
2. Carry: exp=127, mant=25'h1800000, grs=0 -> 32'h40400000 (3.0), out_valid at k+3.
3. Left shift: exp=130, mant=25'h0200000 -> 2 shifts, 32'h40000000, out_valid at k+5.
4. RNE tie: exp=127, mant=25'h0800001, grs=3'b100 -> 32'h3F800002, inexact=1. Same with mant=25'h0800002 -> 32'h3F800002 (no round-up), inexact=1.
5. Overflow: exp=254, mant=25'h1FFFFFF, grs=3'b111 -> 32'h7F800000, overflow=1.
6. Zero, backpressure and reset:
   - mant=0, grs=0 -> 32'h00000000.
   - out_ready low for 5 cycles -> result stable and in_ready=0 throughout.
   - rst asserted during NORM of a shift-5 case -> out_valid never rises; IDLE with in_ready=1 next cycle.
